// File: rtl/weight_prefetch_ctrl.sv
// Weight-tile prefetch sequencer: streams global memory words into the inactive weight bank
// and optionally swaps buffers. Optional running checksum under WEIGHT_PREFETCH_CHECKSUM_EN.
module weight_prefetch_ctrl #(
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned EXT_ADDR_BITS = 16,
  parameter int unsigned NUM_BANKS     = 4,
  parameter int unsigned BANK_DEPTH    = 1024,
  parameter int unsigned LEN_BITS      = $clog2(NUM_BANKS*BANK_DEPTH)+1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [EXT_ADDR_BITS-1:0]      cfg_src_addr,
  input  logic [$clog2(NUM_BANKS)-1:0]  cfg_bank,
  input  logic [$clog2(BANK_DEPTH)-1:0] cfg_dst_addr,
  input  logic [LEN_BITS-1:0]           cfg_length,
  input  logic                          cfg_auto_swap,
  input  logic                          abort,
  input  logic                          compute_idle,
  output logic                          mem_read_valid,
  output logic [EXT_ADDR_BITS-1:0]      mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [DATA_BITS-1:0]          mem_read_data,
  output logic                          wm_write_en,
  output logic [$clog2(NUM_BANKS)-1:0]  wm_write_bank,
  output logic [$clog2(BANK_DEPTH)-1:0] wm_write_addr,
  output logic [DATA_BITS-1:0]          wm_write_data,
  output logic                          wm_swap,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [LEN_BITS-1:0]           words_written,
  output logic [DATA_BITS-1:0]          checksum
);

  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
  localparam int unsigned WADDR_BITS = $clog2(BANK_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WRITE, S_WAIT_SWAP, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     abort_q, abort_d;
  logic                     auto_swap_q, auto_swap_d;
  logic [LEN_BITS-1:0]      len_q, len_d;
  logic                     mem_read_valid_d;
  logic [EXT_ADDR_BITS-1:0] mem_read_address_d;
  logic                     wm_write_en_d;
  logic [BANK_BITS-1:0]     wm_write_bank_d;
  logic [WADDR_BITS-1:0]    wm_write_addr_d;
  logic [DATA_BITS-1:0]     wm_write_data_d;
  logic                     done_d, aborted_d;
  logic [LEN_BITS-1:0]      words_written_d;
  logic                     abort_eff_c;

  // A pending abort is either already latched or arriving this cycle.
  assign abort_eff_c = abort_q | abort;

  // Next-state and next-output logic; the write pointers double as the bank port outputs.
  always_comb begin
    state_d            = state_q;
    abort_d            = abort_q;
    auto_swap_d        = auto_swap_q;
    len_d              = len_q;
    mem_read_valid_d   = 1'b0;
    mem_read_address_d = mem_read_address;
    wm_write_en_d      = 1'b0;
    wm_write_bank_d    = wm_write_bank;
    wm_write_addr_d    = wm_write_addr;
    wm_write_data_d    = wm_write_data;
    done_d             = 1'b0;
    aborted_d          = 1'b0;
    words_written_d    = words_written;
    wm_swap            = 1'b0;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          auto_swap_d        = cfg_auto_swap;
          len_d              = cfg_length;
          mem_read_address_d = cfg_src_addr;
          wm_write_bank_d    = cfg_bank;
          wm_write_addr_d    = cfg_dst_addr;
          words_written_d    = '0;
          if (cfg_length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d          = S_REQ;
            mem_read_valid_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        abort_d          = abort_eff_c;
        mem_read_valid_d = 1'b1;
        if (mem_read_ready) begin
          mem_read_valid_d = 1'b0;
          if (abort_eff_c) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end else begin
            state_d         = S_WRITE;
            wm_write_en_d   = 1'b1;
            wm_write_data_d = mem_read_data;
          end
        end
      end
      S_WRITE: begin
        abort_d            = abort_eff_c;
        words_written_d    = words_written + LEN_BITS'(1);
        mem_read_address_d = mem_read_address + EXT_ADDR_BITS'(1);
        wm_write_addr_d    = wm_write_addr + WADDR_BITS'(1);
        if (wm_write_addr == WADDR_BITS'(BANK_DEPTH-1))
          wm_write_bank_d = wm_write_bank + BANK_BITS'(1);
        if (abort_eff_c) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (words_written_d == len_q) begin
          if (auto_swap_q) begin
            state_d = S_WAIT_SWAP;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d          = S_REQ;
          mem_read_valid_d = 1'b1;
        end
      end
      S_WAIT_SWAP: begin
        abort_d = abort_eff_c;
        if (abort_eff_c) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (compute_idle) begin
          wm_swap = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      abort_q          <= 1'b0;
      auto_swap_q      <= 1'b0;
      len_q            <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      wm_write_en      <= 1'b0;
      wm_write_bank    <= '0;
      wm_write_addr    <= '0;
      wm_write_data    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      aborted          <= 1'b0;
      words_written    <= '0;
    end else begin
      state_q          <= state_d;
      abort_q          <= abort_d;
      auto_swap_q      <= auto_swap_d;
      len_q            <= len_d;
      mem_read_valid   <= mem_read_valid_d;
      mem_read_address <= mem_read_address_d;
      wm_write_en      <= wm_write_en_d;
      wm_write_bank    <= wm_write_bank_d;
      wm_write_addr    <= wm_write_addr_d;
      wm_write_data    <= wm_write_data_d;
      busy             <= (state_d != S_IDLE);
      done             <= done_d;
      aborted          <= aborted_d;
      words_written    <= words_written_d;
    end
  end

`ifdef WEIGHT_PREFETCH_CHECKSUM_EN
  logic [DATA_BITS-1:0] checksum_d;

  // Running sum of committed words, cleared by an accepted start.
  always_comb begin
    checksum_d = checksum;
    if (state_q == S_IDLE && start)
      checksum_d = '0;
    else if (state_q == S_WRITE)
      checksum_d = checksum + wm_write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) checksum <= '0;
    else        checksum <= checksum_d;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_prefetch_ctrl.sv
// Directed bench for weight_prefetch_ctrl; memory data is a fixed function of the read address.
module tb_weight_prefetch_ctrl;

`ifdef WEIGHT_PREFETCH_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_src_addr = '0;
  logic [1:0]  cfg_bank = '0;
  logic [9:0]  cfg_dst_addr = '0;
  logic [12:0] cfg_length = '0;
  logic        cfg_auto_swap = 1'b0;
  logic        abort = 1'b0;
  logic        compute_idle = 1'b0;
  logic        mem_read_valid;
  logic [15:0] mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic        wm_write_en;
  logic [1:0]  wm_write_bank;
  logic [9:0]  wm_write_addr;
  logic [15:0] wm_write_data;
  logic        wm_swap;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [12:0] words_written;
  logic [15:0] checksum;

  weight_prefetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_src_addr(cfg_src_addr), .cfg_bank(cfg_bank), .cfg_dst_addr(cfg_dst_addr),
    .cfg_length(cfg_length), .cfg_auto_swap(cfg_auto_swap), .abort(abort),
    .compute_idle(compute_idle), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .wm_write_en(wm_write_en), .wm_write_bank(wm_write_bank),
    .wm_write_addr(wm_write_addr), .wm_write_data(wm_write_data), .wm_swap(wm_swap),
    .busy(busy), .done(done), .aborted(aborted), .words_written(words_written),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Memory responder: ready after ready_delay stalled cycles; data = address - 0x60.
  int ready_delay = 0;
  int wait_cnt = 0;
  always @(posedge clk)
    wait_cnt <= (mem_read_valid && !mem_read_ready) ? wait_cnt + 1 : 0;
  assign mem_read_ready = mem_read_valid && (wait_cnt >= ready_delay);
  assign mem_read_data  = mem_read_address - 16'h0060;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int wr_n = 0, rd_n = 0, swap_n = 0, done_n = 0, abt_n = 0;
  int done_cyc = 0, swap_cyc = 0, abt_cyc = 0;
  logic [1:0]  wr_bank [64];
  logic [9:0]  wr_addr [64];
  logic [15:0] wr_data [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wm_write_en) begin
      wr_bank[wr_n % 64] <= wm_write_bank;
      wr_addr[wr_n % 64] <= wm_write_addr;
      wr_data[wr_n % 64] <= wm_write_data;
      wr_n <= wr_n + 1;
    end
    if (mem_read_valid) rd_n <= rd_n + 1;
    if (wm_swap) begin swap_n <= swap_n + 1; swap_cyc <= cyc; end
    if (done)    begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (aborted) begin abt_n  <= abt_n + 1;  abt_cyc  <= cyc; end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] src, input logic [1:0] bank, input logic [9:0] dst,
                          input logic [12:0] len, input logic swp, output int sc);
    cfg_src_addr  = src;
    cfg_bank      = bank;
    cfg_dst_addr  = dst;
    cfg_length    = len;
    cfg_auto_swap = swp;
    start = 1'b1;
    sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int d0, input int a0);
    bit ended = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done_n != d0 || abt_n != a0) begin
        ended = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_terminates"}, 32'(ended), 32'd1);
    step();
  endtask

  int sc, w0, r0, d0, a0, s0, ic;

  initial begin
    // Reset state
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_wen", 32'(wm_write_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b1;
    step(2);

    // Basic load: 4 words into bank 1 from 0x010
    w0 = wr_n; d0 = done_n; a0 = abt_n; s0 = swap_n;
    do_start(16'h0100, 2'd1, 10'h010, 13'd4, 1'b0, sc);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_valid", 32'(mem_read_valid), 32'd1);
    chk("basic_addr", 32'(mem_read_address), 32'h0100);
    wait_end("basic", d0, a0);
    chk("basic_nwrites", 32'(wr_n - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_bank%0d", i), 32'(wr_bank[w0 + i]), 32'd1);
      chk($sformatf("basic_waddr%0d", i), 32'(wr_addr[w0 + i]), 32'h010 + 32'(i));
      chk($sformatf("basic_wdata%0d", i), 32'(wr_data[w0 + i]), 32'h0A0 + 32'(i));
    end
    chk("basic_done_cycle", 32'(done_cyc - sc), 32'd9);
    chk("basic_no_swap", 32'(swap_n - s0), 32'd0);
    chk("basic_words", 32'(words_written), 32'd4);
    chk("basic_checksum", 32'(checksum), CK_EN ? 32'h0286 : 32'd0);
    chk("basic_idle", 32'(busy), 32'd0);

    // Bank crossing
    w0 = wr_n; d0 = done_n; a0 = abt_n;
    do_start(16'h0200, 2'd3, 10'h3FE, 13'd3, 1'b0, sc);
    wait_end("cross", d0, a0);
    chk("cross_nwrites", 32'(wr_n - w0), 32'd3);
    chk("cross_b0", {wr_bank[w0], 6'd0, wr_addr[w0]}, {2'd3, 6'd0, 10'h3FE});
    chk("cross_b1", {wr_bank[w0+1], 6'd0, wr_addr[w0+1]}, {2'd3, 6'd0, 10'h3FF});
    chk("cross_b2", {wr_bank[w0+2], 6'd0, wr_addr[w0+2]}, {2'd0, 6'd0, 10'h000});
    chk("cross_data2", 32'(wr_data[w0+2]), 32'h01A2);
    chk("cross_words", 32'(words_written), 32'd3);
    chk("cross_checksum", 32'(checksum), CK_EN ? 32'h04E3 : 32'd0);

    // Zero length
    w0 = wr_n; r0 = rd_n; d0 = done_n;
    do_start(16'h0500, 2'd0, 10'h000, 13'd0, 1'b0, sc);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(mem_read_valid), 32'd0);
    step(2);
    chk("zero_one_done", 32'(done_n - d0), 32'd1);
    chk("zero_no_reads", 32'(rd_n - r0), 32'd0);
    chk("zero_no_writes", 32'(wr_n - w0), 32'd0);
    chk("zero_words", 32'(words_written), 32'd0);
    chk("zero_checksum", 32'(checksum), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);

    // Auto swap, compute_idle low for several WAIT_SWAP cycles
    d0 = done_n; a0 = abt_n; s0 = swap_n;
    compute_idle = 1'b0;
    do_start(16'h0100, 2'd2, 10'h000, 13'd2, 1'b1, sc);
    step(4);
    chk("swap_wait_busy", 32'(busy), 32'd1);
    chk("swap_wait_noswap", 32'(wm_swap), 32'd0);
    step(4);
    chk("swap_still_wait", 32'(done_n - d0), 32'd0);
    compute_idle = 1'b1;
    ic = cyc;
    #1;
    chk("swap_pulse_now", 32'(wm_swap), 32'd1);
    wait_end("swap", d0, a0);
    compute_idle = 1'b0;
    chk("swap_count", 32'(swap_n - s0), 32'd1);
    chk("swap_cycle", 32'(swap_cyc - ic), 32'd0);
    chk("swap_done_next", 32'(done_cyc - ic), 32'd1);
    chk("swap_words", 32'(words_written), 32'd2);

    // Abort during the third request with ready stalled 3 cycles
    w0 = wr_n; d0 = done_n; a0 = abt_n;
    ready_delay = 3;
    do_start(16'h0100, 2'd0, 10'h040, 13'd8, 1'b0, sc);
    step(11);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid_held", 32'(mem_read_valid), 32'd1);
    chk("abort_addr_held", 32'(mem_read_address), 32'h0102);
    wait_end("abort", d0, a0);
    ready_delay = 0;
    chk("abort_nwrites", 32'(wr_n - w0), 32'd2);
    chk("abort_pulse", 32'(abt_n - a0), 32'd1);
    chk("abort_cycle", 32'(abt_cyc - sc), 32'd15);
    chk("abort_no_done", 32'(done_n - d0), 32'd0);
    chk("abort_words", 32'(words_written), 32'd2);

    // Abort while idle has no effect on the next transfer
    abort = 1'b1;
    step();
    abort = 1'b0;
    d0 = done_n; a0 = abt_n;
    do_start(16'h0100, 2'd0, 10'h000, 13'd1, 1'b0, sc);
    wait_end("idle_abort", d0, a0);
    chk("idle_abort_done", 32'(done_n - d0), 32'd1);
    chk("idle_abort_noabt", 32'(abt_n - a0), 32'd0);

    // Reset during the second word's write
    d0 = done_n; s0 = swap_n;
    do_start(16'h0100, 2'd1, 10'h100, 13'd4, 1'b1, sc);
    step(3);
    chk("rstmid_in_write", 32'(wm_write_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_wen", 32'(wm_write_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_valid", 32'(mem_read_valid), 32'd0);
    chk("rstmid_words", 32'(words_written), 32'd0);
    chk("rstmid_bank_addr", {wm_write_bank, wm_write_addr}, 32'd0);
    chk("rstmid_wdata", 32'(wm_write_data), 32'd0);
    chk("rstmid_raddr", 32'(mem_read_address), 32'd0);
    chk("rstmid_checksum", 32'(checksum), 32'd0);
    step(2);
    reset = 1'b1;
    step(2);
    chk("rstmid_no_done", 32'(done_n - d0), 32'd0);
    chk("rstmid_no_swap", 32'(swap_n - s0), 32'd0);

    // Stray start while busy is ignored
    w0 = wr_n; d0 = done_n; a0 = abt_n;
    do_start(16'h0100, 2'd2, 10'h020, 13'd3, 1'b0, sc);
    step(2);
    cfg_src_addr = 16'h0000; cfg_bank = 2'd0; cfg_dst_addr = 10'h000; cfg_length = 13'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_end("stray", d0, a0);
    chk("stray_nwrites", 32'(wr_n - w0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stray_bank%0d", i), 32'(wr_bank[w0 + i]), 32'd2);
      chk($sformatf("stray_waddr%0d", i), 32'(wr_addr[w0 + i]), 32'h020 + 32'(i));
      chk($sformatf("stray_wdata%0d", i), 32'(wr_data[w0 + i]), 32'h0A0 + 32'(i));
    end
    chk("stray_done_cycle", 32'(done_cyc - sc), 32'd7);
    chk("stray_words", 32'(words_written), 32'd3);
    chk("stray_checksum", 32'(checksum), CK_EN ? 32'h01E3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_prefetch_ctrl.md
Name: weight_prefetch_ctrl

Overview:
Sequencer that streams a weight tile from global memory into the inactive buffer of the double-buffered weight banks. It drives the bank write port word by word, and optionally issues the buffer swap once the compute side reports idle. It sits between the global memory read channel and the weight/activation memory block, and is commanded by the dispatcher through a start/done handshake.

Parameters:
- DATA_BITS, 16, weight word width
- EXT_ADDR_BITS, 16, global memory address width
- NUM_BANKS, 4, weight banks (power of 2)
- BANK_DEPTH, 1024, words per bank (power of 2)
- LEN_BITS, $clog2(NUM_BANKS*BANK_DEPTH)+1, transfer-length width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle command pulse
- cfg_src_addr  in  EXT_ADDR_BITS  first global word address
- cfg_bank  in  $clog2(NUM_BANKS)  first destination bank
- cfg_dst_addr  in  $clog2(BANK_DEPTH)  first destination word in bank
- cfg_length  in  LEN_BITS  words to move (0 allowed)
- cfg_auto_swap  in  1  request buffer swap after load
- abort  in  1  stop transfer at next word boundary
- compute_idle  in  1  consumer finished with active buffer
- mem_read_valid  out  1  global read request
- mem_read_address  out  EXT_ADDR_BITS  global read address
- mem_read_ready  in  1  read accepted, data valid this cycle
- mem_read_data  in  DATA_BITS  read data
- wm_write_en  out  1  bank write strobe
- wm_write_bank  out  $clog2(NUM_BANKS)  bank select
- wm_write_addr  out  $clog2(BANK_DEPTH)  word address
- wm_write_data  out  DATA_BITS  write data
- wm_swap  out  1  one-cycle buffer swap pulse
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- aborted  out  1  one-cycle abort pulse
- words_written  out  LEN_BITS  words committed in current/last transfer
- checksum  out  DATA_BITS  see Optional Feature

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; internal counters 0.
- FSM states: IDLE, REQ, WRITE, WAIT_SWAP, DONE.
- IDLE: on start, latch all cfg_* inputs and clear words_written.
  - cfg_length==0 → DONE (no reads, no swap).
  - Otherwise → REQ.
  - start while busy is ignored.
- REQ:
  - mem_read_valid=1 with the current source address, both held stable until mem_read_ready.
  - On ready: latch mem_read_data → WRITE. Ready in the first REQ cycle is legal.
- WRITE:
  - wm_write_en=1 for exactly one cycle with the latched bank, address and data.
  - Then words_written+1, source address+1 (wraps mod 2^EXT_ADDR_BITS).
  - Destination address+1; at BANK_DEPTH-1 it wraps to 0 and the bank increments mod NUM_BANKS.
  - If words_written reaches cfg_length: → WAIT_SWAP when cfg_auto_swap, else → DONE. Otherwise → REQ.
- Throughput: 2 cycles per word with zero-wait memory.
- WAIT_SWAP:
  - Wait for compute_idle=1. On that cycle pulse wm_swap → DONE.
  - compute_idle already high on entry gives the swap on the first WAIT_SWAP cycle.
- DONE: done=1 for one cycle → IDLE.
- abort:
  - Sampled every cycle; latched while busy.
  - In REQ, an outstanding request still completes (valid is never dropped before ready). The fetched word is discarded and not written.
  - In WRITE, the current word is written first.
  - In WAIT_SWAP, no swap is issued.
  - Then aborted=1 for one cycle → IDLE. done is not asserted.
  - abort in IDLE has no effect.
- busy=1 in every state except IDLE.
- words_written holds its value after a transfer until the next accepted start.
- Reset mid-transfer: immediate return to IDLE. Partially written words remain in the banks; no done, no swap.

Optional Feature:
- Macro WEIGHT_PREFETCH_CHECKSUM_EN.
- Defined: checksum clears on accepted start and adds each written word (DATA_BITS wrap-around) in the WRITE cycle. It is stable from the done pulse until the next start.
- Undefined: checksum tied to 0, no adder logic.

Test Plan:
- Basic load: src=0x0100, bank=1, dst=0x010, len=4, data 0xA0..0xA3, ready immediate.
  - 4 writes to bank 1, addr 0x010..0x013.
  - done at cycle 9 after start; no wm_swap; words_written=4.
  - checksum=0x0286 when enabled.
- Bank crossing: bank=3, dst=0x3FE, len=3.
  - Writes to (3,0x3FE), (3,0x3FF), (0,0x000).
- Zero length: len=0.
  - done one cycle after IDLE accepts start; no mem_read_valid, no wm_write_en.
- Auto swap: len=2, cfg_auto_swap=1, compute_idle held 0 for 5 cycles then 1.
  - wm_swap single pulse in the cycle compute_idle=1; done next cycle.
- Abort with ready stalled: len=8, abort during 3rd REQ, ready delayed 3 cycles.
  - mem_read_valid held until ready; only 2 writes; aborted pulse, no done, words_written=2.
- Reset and stray start: reset low during WRITE of word 2.
  - All outputs 0 immediately; a start issued while busy in a later transfer is ignored, and that transfer completes unchanged.
